// File: rtl/imm_pkg.sv
// Shared definitions for the decode-stage immediate generator.
//   imm_kind_e : immediate class reported on kind_out
//   OPC_*      : every opcode that carries an immediate
//   classify() : opcode -> immediate class
package imm_pkg;

  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_SHORT = 2'd1,
    IMM_LONG  = 2'd2,
    IMM_UPPER = 2'd3
  } imm_kind_e;

  // Opcodes using the 6-bit immediate field
  localparam logic [3:0] OPC_SHORT0 = 4'b0000;
  localparam logic [3:0] OPC_SHORT1 = 4'b0100;
  localparam logic [3:0] OPC_SHORT2 = 4'b0101;
  localparam logic [3:0] OPC_SHORT3 = 4'b1000;
  localparam logic [3:0] OPC_SHORT4 = 4'b1001;
  localparam logic [3:0] OPC_SHORT5 = 4'b1010;
  // Opcodes using the 9-bit immediate field
  localparam logic [3:0] OPC_LONG0  = 4'b1100;
  localparam logic [3:0] OPC_LONG1  = 4'b1111;
  // Upper-immediate opcode
  localparam logic [3:0] OPC_UPPER  = 4'b0011;

  function automatic imm_kind_e classify(input logic [3:0] opc);
    imm_kind_e kind;
    case (opc)
      OPC_SHORT0, OPC_SHORT1, OPC_SHORT2,
      OPC_SHORT3, OPC_SHORT4, OPC_SHORT5: kind = IMM_SHORT;
      OPC_LONG0, OPC_LONG1:               kind = IMM_LONG;
      OPC_UPPER:                          kind = IMM_UPPER;
      default:                            kind = IMM_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction.
//   ir_i   : instruction word
//   zext_i : 1 = zero-extend SHORT/LONG fields instead of sign-extending
//   imm_o  : XLEN-wide immediate (0 for opcodes without an immediate)
//   kind_o : immediate class
// The opcode constants are 4 bits wide, so OPC_W is expected to be 4.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 16,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned IMM6_W      = 6,
  parameter int unsigned IMM9_W      = 9,
  parameter int unsigned UPPER_SHIFT = 7
) (
  input  logic [XLEN-1:0] ir_i,
  input  logic            zext_i,
  output logic [XLEN-1:0] imm_o,
  output imm_kind_e       kind_o
);

  logic [OPC_W-1:0]  opc;
  logic [IMM6_W-1:0] f6;
  logic [IMM9_W-1:0] f9;
  logic              sx6, sx9;
  logic [XLEN-1:0]   ext6, ext9, upper;
  logic              unused_ir;

  assign opc = ir_i[XLEN-1 -: OPC_W];
  assign f6  = ir_i[IMM6_W-1:0];
  assign f9  = ir_i[IMM9_W-1:0];

  // Fill bit is the field MSB unless zero-extension is requested
  assign sx6  = f6[IMM6_W-1] & ~zext_i;
  assign sx9  = f9[IMM9_W-1] & ~zext_i;
  assign ext6 = {{(XLEN-IMM6_W){sx6}}, f6};
  assign ext9 = {{(XLEN-IMM9_W){sx9}}, f9};
  // Bits shifted past XLEN are discarded (truncation)
  assign upper = XLEN'(f9) << UPPER_SHIFT;

  // Bits between the immediate field and the opcode are register specifiers
  assign unused_ir = ^ir_i[XLEN-OPC_W-1:IMM9_W];

  always_comb begin
    kind_o = classify(opc);
    imm_o  = '0;
    case (kind_o)
      IMM_SHORT: imm_o = ext6;
      IMM_LONG:  imm_o = ext9;
      IMM_UPPER: imm_o = upper;
      default:   imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer.
//   clk, rst            : clock / asynchronous active-high reset
//   flush               : drop every buffered entry and the same-cycle input
//   in_valid/in_ready   : upstream handshake, in_ready = !skid_valid
//   ir_in, zext_in      : instruction word and zero-extend request
//   out_valid/out_ready : downstream handshake
//   imm_out, kind_out   : registered immediate and its class
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 16,
  parameter int unsigned OPC_W       = 4,
  parameter int unsigned IMM6_W      = 6,
  parameter int unsigned IMM9_W      = 9,
  parameter int unsigned UPPER_SHIFT = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ir_in,
  input  logic            zext_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [1:0]      kind_out
);

  logic [XLEN-1:0] new_imm;
  imm_kind_e       new_kind;

  imm_extract #(
    .XLEN        (XLEN),
    .OPC_W       (OPC_W),
    .IMM6_W      (IMM6_W),
    .IMM9_W      (IMM9_W),
    .UPPER_SHIFT (UPPER_SHIFT)
  ) u_extract (
    .ir_i   (ir_in),
    .zext_i (zext_in),
    .imm_o  (new_imm),
    .kind_o (new_kind)
  );

  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  imm_kind_e       out_kind_q, out_kind_d;
  imm_kind_e       skid_kind_q, skid_kind_d;
  logic            accept;

  // Registered-only: no combinational path from out_ready
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_imm_d    = out_imm_q;
    out_kind_d   = out_kind_q;
    skid_imm_d   = skid_imm_q;
    skid_kind_d  = skid_kind_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot is free this edge; skid is older than any new input.
      // With skid full in_ready is low, so no accept can coincide.
      if (skid_valid_q) begin
        out_imm_d    = skid_imm_q;
        out_kind_d   = skid_kind_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_imm_d   = new_imm;
        out_kind_d  = new_kind;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new entry in the skid register
      skid_imm_d   = new_imm;
      skid_kind_d  = new_kind;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_imm_q    <= '0;
      out_kind_q   <= IMM_NONE;
      skid_imm_q   <= '0;
      skid_kind_q  <= IMM_NONE;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_imm_q    <= out_imm_d;
      out_kind_q   <= out_kind_d;
      skid_imm_q   <= skid_imm_d;
      skid_kind_q  <= skid_kind_d;
    end
  end

  assign out_valid = out_valid_q;
  assign imm_out   = out_imm_q;
  assign kind_out  = out_kind_q;

endmodule
